// File: rtl/lcd_sequencer.sv
// LCD init/stream sequencer.
// Walks an init ROM of {kind, value} words and turns each command/data byte
// into register accesses on a memory-mapped SPI controller (DC select, DATA,
// CTRL start, STATUS poll). Once the ROM ends it streams RGB565 pixels as
// RAMWR-prefixed frames. One bus transaction is outstanding at most; every
// bus field is a register held until the accepting edge.
module lcd_sequencer #(
    parameter int DELAY_UNIT = 1000,
    parameter int ROM_AW     = 6,
    parameter int POLL_MAX   = 4096
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [ROM_AW-1:0] rom_addr,
    input  logic [9:0]        rom_data,
    input  logic              pix_valid,
    output logic              pix_ready,
    input  logic [15:0]       pix_data,
    input  logic              pix_last,
    output logic [31:0]       m_address,
    output logic              m_sel,
    output logic              m_read,
    output logic [3:0]        m_write_mask,
    output logic [31:0]       m_write_value,
    input  logic [31:0]       m_read_value,
    input  logic              m_ready
);

    localparam int DW = 8 + $clog2(DELAY_UNIT + 1);
    localparam int PW = $clog2(POLL_MAX + 1);

    localparam logic [31:0] ADDR_DATA   = 32'h0000_0000;
    localparam logic [31:0] ADDR_CTRL   = 32'h0000_0004;
    localparam logic [31:0] ADDR_STATUS = 32'h0000_0008;
    localparam logic [31:0] ADDR_DC     = 32'h0000_000C;
    localparam logic [7:0]  CMD_RAMWR   = 8'h2C;

    typedef enum logic [3:0] {
        ST_IDLE        = 4'd0,
        ST_FETCH       = 4'd1,
        ST_WR_DC       = 4'd2,
        ST_WR_DATA     = 4'd3,
        ST_WR_CTRL     = 4'd4,
        ST_POLL        = 4'd5,
        ST_DELAY       = 4'd6,
        ST_STREAM_IDLE = 4'd7,
        ST_STREAM_HI   = 4'd8,
        ST_STREAM_LO   = 4'd9
    } state_e;

    // Where a byte came from, so the end of its STATUS poll knows where to go.
    typedef enum logic [1:0] {
        CTX_INIT  = 2'd0,
        CTX_RAMWR = 2'd1,
        CTX_HI    = 2'd2,
        CTX_LO    = 2'd3
    } ctx_e;

    state_e            state_q;
    ctx_e              ctx_q;
    logic [7:0]        byte_q;
    logic              dc_q;
    logic              dc_last_q;
    logic              dc_valid_q;
    logic [7:0]        pix_lo_q;
    logic              pix_last_q;
    logic [DW-1:0]     delay_q;
    logic [PW-1:0]     poll_q;
    logic [ROM_AW-1:0] rom_addr_q;
    logic              busy_q;
    logic              done_q;
    logic              error_q;
    logic              pix_ready_q;
    logic              m_sel_q;
    logic              m_read_q;
    logic [3:0]        m_mask_q;
    logic [31:0]       m_addr_q;
    logic [31:0]       m_wval_q;

    logic [1:0]        kind_s;
    logic [7:0]        value_s;
    logic [DW-1:0]     delay_load_s;
    logic              last_entry_s;
    logic              poll_last_s;
    logic              status_unused_s;

    assign kind_s          = rom_data[9:8];
    assign value_s         = rom_data[7:0];
    assign delay_load_s    = DW'(value_s) * DW'(DELAY_UNIT);
    assign last_entry_s    = &rom_addr_q;
    assign poll_last_s     = (poll_q == PW'(POLL_MAX - 1));
    assign status_unused_s = ^m_read_value[31:1];

    // A byte only needs a DC write when the line level changes or nothing
    // has been written since start.
    function automatic state_e launch_state_f(input logic dc,
                                              input logic dc_valid,
                                              input logic dc_last);
        return (!dc_valid || (dc != dc_last)) ? ST_WR_DC : ST_WR_DATA;
    endfunction

    // Sequencer FSM: ROM walk, per-byte bus sequence and pixel streaming.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            ctx_q       <= CTX_INIT;
            byte_q      <= 8'h00;
            dc_q        <= 1'b0;
            dc_last_q   <= 1'b0;
            dc_valid_q  <= 1'b0;
            pix_lo_q    <= 8'h00;
            pix_last_q  <= 1'b0;
            delay_q     <= '0;
            poll_q      <= '0;
            rom_addr_q  <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
            pix_ready_q <= 1'b0;
            m_sel_q     <= 1'b0;
            m_read_q    <= 1'b0;
            m_mask_q    <= 4'h0;
            m_addr_q    <= 32'h0000_0000;
            m_wval_q    <= 32'h0000_0000;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        rom_addr_q <= '0;
                        busy_q     <= 1'b1;
                        done_q     <= 1'b0;
                        error_q    <= 1'b0;
                        dc_valid_q <= 1'b0;
                        state_q    <= ST_FETCH;
                    end
                end

                ST_FETCH: begin
                    case (kind_s)
                        2'b00, 2'b01: begin
                            byte_q  <= value_s;
                            dc_q    <= kind_s[0];
                            ctx_q   <= CTX_INIT;
                            state_q <= launch_state_f(kind_s[0], dc_valid_q, dc_last_q);
                        end
                        2'b10: begin
                            // DELAY also serves as the single entry-advance point.
                            delay_q <= delay_load_s;
                            state_q <= ST_DELAY;
                        end
                        2'b11: begin
                            done_q  <= 1'b1;
                            busy_q  <= 1'b0;
                            state_q <= ST_STREAM_IDLE;
                        end
                        default: state_q <= ST_IDLE;
                    endcase
                end

                ST_WR_DC: begin
                    if (!m_sel_q) begin
                        m_sel_q  <= 1'b1;
                        m_read_q <= 1'b0;
                        m_mask_q <= 4'hF;
                        m_addr_q <= ADDR_DC;
                        m_wval_q <= {31'h0000_0000, dc_q};
                    end else if (m_ready) begin
                        m_sel_q    <= 1'b0;
                        m_mask_q   <= 4'h0;
                        dc_last_q  <= dc_q;
                        dc_valid_q <= 1'b1;
                        state_q    <= ST_WR_DATA;
                    end
                end

                ST_WR_DATA: begin
                    if (!m_sel_q) begin
                        m_sel_q  <= 1'b1;
                        m_read_q <= 1'b0;
                        m_mask_q <= 4'hF;
                        m_addr_q <= ADDR_DATA;
                        m_wval_q <= {24'h00_0000, byte_q};
                    end else if (m_ready) begin
                        m_sel_q  <= 1'b0;
                        m_mask_q <= 4'h0;
                        state_q  <= ST_WR_CTRL;
                    end
                end

                ST_WR_CTRL: begin
                    if (!m_sel_q) begin
                        m_sel_q  <= 1'b1;
                        m_read_q <= 1'b0;
                        m_mask_q <= 4'hF;
                        m_addr_q <= ADDR_CTRL;
                        m_wval_q <= 32'h0000_0001;
                    end else if (m_ready) begin
                        m_sel_q  <= 1'b0;
                        m_mask_q <= 4'h0;
                        poll_q   <= '0;
                        state_q  <= ST_POLL;
                    end
                end

                ST_POLL: begin
                    if (!m_sel_q) begin
                        m_sel_q  <= 1'b1;
                        m_read_q <= 1'b1;
                        m_mask_q <= 4'h0;
                        m_addr_q <= ADDR_STATUS;
                        m_wval_q <= 32'h0000_0000;
                    end else if (m_ready) begin
                        m_sel_q  <= 1'b0;
                        m_read_q <= 1'b0;
                        if (!m_read_value[0]) begin
                            case (ctx_q)
                                CTX_INIT: begin
                                    delay_q <= '0;
                                    state_q <= ST_DELAY;
                                end
                                CTX_RAMWR: state_q <= ST_STREAM_HI;
                                CTX_HI:    state_q <= ST_STREAM_LO;
                                CTX_LO: begin
                                    if (pix_last_q) begin
                                        busy_q  <= 1'b0;
                                        state_q <= ST_STREAM_IDLE;
                                    end else begin
                                        state_q <= ST_STREAM_HI;
                                    end
                                end
                                default: begin
                                    busy_q  <= 1'b0;
                                    state_q <= ST_IDLE;
                                end
                            endcase
                        end else if (poll_last_s) begin
                            error_q <= 1'b1;
                            busy_q  <= 1'b0;
                            state_q <= ST_IDLE;
                        end else begin
                            poll_q <= poll_q + PW'(1);
                        end
                    end
                end

                ST_DELAY: begin
                    if (delay_q > DW'(1)) begin
                        delay_q <= delay_q - DW'(1);
                    end else begin
                        delay_q <= '0;
                        if (last_entry_s) begin
                            done_q  <= 1'b1;
                            busy_q  <= 1'b0;
                            state_q <= ST_STREAM_IDLE;
                        end else begin
                            rom_addr_q <= rom_addr_q + ROM_AW'(1);
                            state_q    <= ST_FETCH;
                        end
                    end
                end

                ST_STREAM_IDLE: begin
                    if (start) begin
                        rom_addr_q <= '0;
                        busy_q     <= 1'b1;
                        done_q     <= 1'b0;
                        error_q    <= 1'b0;
                        dc_valid_q <= 1'b0;
                        state_q    <= ST_FETCH;
                    end else if (pix_valid) begin
                        busy_q  <= 1'b1;
                        byte_q  <= CMD_RAMWR;
                        dc_q    <= 1'b0;
                        ctx_q   <= CTX_RAMWR;
                        state_q <= launch_state_f(1'b0, dc_valid_q, dc_last_q);
                    end
                end

                ST_STREAM_HI: begin
                    // pix_ready is raised for one cycle; the pixel is taken on that cycle.
                    if (pix_ready_q) begin
                        pix_ready_q <= 1'b0;
                        if (pix_valid) begin
                            pix_lo_q   <= pix_data[7:0];
                            pix_last_q <= pix_last;
                            byte_q     <= pix_data[15:8];
                            dc_q       <= 1'b1;
                            ctx_q      <= CTX_HI;
                            state_q    <= launch_state_f(1'b1, dc_valid_q, dc_last_q);
                        end
                    end else if (pix_valid) begin
                        pix_ready_q <= 1'b1;
                    end
                end

                ST_STREAM_LO: begin
                    byte_q  <= pix_lo_q;
                    dc_q    <= 1'b1;
                    ctx_q   <= CTX_LO;
                    state_q <= launch_state_f(1'b1, dc_valid_q, dc_last_q);
                end

                default: begin
                    busy_q  <= 1'b0;
                    m_sel_q <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy          = busy_q;
    assign done          = done_q;
    assign error         = error_q;
    assign rom_addr      = rom_addr_q;
    assign pix_ready     = pix_ready_q;
    assign m_sel         = m_sel_q;
    assign m_read        = m_read_q;
    assign m_write_mask  = m_mask_q;
    assign m_address     = m_addr_q;
    assign m_write_value = m_wval_q;

endmodule

// File: tb/tb_lcd_sequencer.sv
// Self-checking bench for lcd_sequencer: directed and randomized scenarios
// compared against a transaction-list reference model.
module tb_lcd_sequencer;

    localparam int DU = 10;
    localparam int AW = 3;
    localparam int PM = 8;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          start = 1'b0;
    logic          busy, done, error;
    logic [AW-1:0] rom_addr;
    logic [9:0]    rom_data;
    logic          pix_valid = 1'b0;
    logic          pix_ready;
    logic [15:0]   pix_data = 16'h0000;
    logic          pix_last = 1'b0;
    logic [31:0]   m_address;
    logic          m_sel, m_read;
    logic [3:0]    m_write_mask;
    logic [31:0]   m_write_value;
    logic [31:0]   m_read_value;
    logic          m_ready = 1'b0;

    lcd_sequencer #(.DELAY_UNIT(DU), .ROM_AW(AW), .POLL_MAX(PM)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .busy(busy), .done(done),
        .error(error), .rom_addr(rom_addr), .rom_data(rom_data),
        .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_data(pix_data),
        .pix_last(pix_last), .m_address(m_address), .m_sel(m_sel),
        .m_read(m_read), .m_write_mask(m_write_mask),
        .m_write_value(m_write_value), .m_read_value(m_read_value),
        .m_ready(m_ready)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        rd;
        logic [3:0]  mask;
        logic [31:0] addr;
        logic [31:0] wval;
    } txn_t;

    logic [9:0]  rom [0:7];
    logic [15:0] frame_px [0:3];
    assign rom_data = rom[rom_addr];

    int checks = 0;
    int errors = 0;

    // bus responder / status model state
    int          busy_k = 2;
    int          stall_max = 0;
    bit          stall_rand = 1'b0;
    int          stall_left = 0;
    int          poll_idx = 0;
    logic [30:0] rv_hi = '0;
    assign m_read_value = {rv_hi, (poll_idx < busy_k) ? 1'b1 : 1'b0};

    // monitor state
    txn_t        obs_q[$];
    int          obs_hold_q[$];
    int          cur_hold = 0;
    bit          prev_wait = 1'b0;
    bit          prev_acc = 1'b0;
    logic [68:0] prev_fields = '0;
    int          stab_viol = 0;
    int          gap_viol = 0;
    int          pr_viol = 0;
    int          pix_rdy_cycles = 0;

    // reference model state
    txn_t exp_q[$];
    int   mdl_dc;
    bit   mdl_err;
    int   mdl_end;

    // Slave: random or fixed wait states, chosen while the bus is idle.
    always @(negedge clk) begin
        rv_hi <= 31'($urandom);
        if (!m_sel) begin
            m_ready    <= 1'b0;
            stall_left <= stall_rand ? int'($urandom_range(stall_max, 0)) : stall_max;
        end else if (stall_left == 0) begin
            m_ready <= 1'b1;
        end else begin
            m_ready    <= 1'b0;
            stall_left <= stall_left - 1;
        end
    end

    // Monitor: log accepted transactions and protocol violations.
    always @(posedge clk) begin
        if (m_sel && m_ready) begin
            obs_q.push_back(txn_t'{m_read, m_write_mask, m_address, m_write_value});
            obs_hold_q.push_back(cur_hold + 1);
            cur_hold <= 0;
            if (m_read) poll_idx <= poll_idx + 1;
            else if (m_address == 32'h4) poll_idx <= 0;
        end else if (m_sel) begin
            cur_hold <= cur_hold + 1;
        end else begin
            cur_hold <= 0;
        end
        if (prev_wait && reset_n &&
            (!m_sel || ({m_read, m_write_mask, m_address, m_write_value} != prev_fields)))
            stab_viol <= stab_viol + 1;
        prev_wait   <= m_sel && !m_ready && reset_n;
        prev_fields <= {m_read, m_write_mask, m_address, m_write_value};
        if (prev_acc && m_sel) gap_viol <= gap_viol + 1;
        prev_acc <= m_sel && m_ready;
        if (pix_ready) begin
            pix_rdy_cycles <= pix_rdy_cycles + 1;
            if (m_sel) pr_viol <= pr_viol + 1;
        end
    end

    task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push_exp(input logic rd, input logic [31:0] addr, input logic [31:0] wv);
        exp_q.push_back(txn_t'{rd, rd ? 4'h0 : 4'hF, addr, rd ? 32'h0 : wv});
    endtask

    // One byte: optional DC write, DATA, CTRL start, then STATUS reads.
    task automatic model_byte(input logic [7:0] b, input logic dc);
        int polls;
        if (mdl_err) return;
        if (mdl_dc != int'(dc)) begin
            push_exp(1'b0, 32'hC, {31'h0, dc});
            mdl_dc = int'(dc);
        end
        push_exp(1'b0, 32'h0, {24'h0, b});
        push_exp(1'b0, 32'h4, 32'h1);
        polls = (busy_k + 1 > PM) ? PM : busy_k + 1;
        for (int i = 0; i < polls; i++) push_exp(1'b1, 32'h8, 32'h0);
        if (busy_k + 1 > PM) mdl_err = 1'b1;
    endtask

    task automatic model_init();
        mdl_dc  = -1;
        mdl_err = 1'b0;
        mdl_end = 7;
        for (int a = 0; a < 8; a++) begin
            mdl_end = a;
            if (rom[a][9:8] == 2'b11) break;
            if (rom[a][9:8] != 2'b10) model_byte(rom[a][7:0], rom[a][8]);
            if (mdl_err) break;
        end
    endtask

    task automatic compare(input string tag, input int base, input bit hold_chk);
        chk($sformatf("%s_count", tag), 80'(obs_q.size() - base), 80'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && base + i < obs_q.size(); i++) begin
            txn_t o;
            o = obs_q[base + i];
            if (exp_q[i].rd) o.wval = 32'h0;
            chk($sformatf("%s_txn%0d", tag, i), 80'(o), 80'(exp_q[i]));
            if (hold_chk)
                chk($sformatf("%s_hold%0d", tag, i), 80'(obs_hold_q[base + i]), 80'(stall_max + 1));
        end
    endtask

    task automatic pulse_start();
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
    endtask

    task automatic wait_not_busy(input string tag, input int budget);
        int n = 0;
        while (busy && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk($sformatf("%s_timeout", tag), 80'(busy), 80'(0));
    endtask

    task automatic run_init(input string tag, input bit glitch, input bit hold_chk);
        int base;
        base = obs_q.size();
        exp_q.delete();
        model_init();
        pulse_start();
        if (glitch) begin
            repeat (6) @(negedge clk);
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
        end
        wait_not_busy(tag, 4000);
        compare(tag, base, hold_chk);
        chk($sformatf("%s_done", tag), 80'(done), 80'(!mdl_err));
        chk($sformatf("%s_error", tag), 80'(error), 80'(mdl_err));
        chk($sformatf("%s_rom_addr", tag), 80'(rom_addr), 80'(mdl_end));
        chk($sformatf("%s_msel", tag), 80'(m_sel), 80'(0));
    endtask

    task automatic run_frame(input string tag, input int n);
        int base, rb, w;
        base = obs_q.size();
        rb   = pix_rdy_cycles;
        exp_q.delete();
        model_byte(8'h2C, 1'b0);
        for (int i = 0; i < n; i++) begin
            model_byte(frame_px[i][15:8], 1'b1);
            model_byte(frame_px[i][7:0], 1'b1);
        end
        for (int i = 0; i < n; i++) begin
            pix_valid = 1'b1;
            pix_data  = frame_px[i];
            pix_last  = (i == n - 1);
            w = 0;
            while (!pix_ready && w < 500) begin
                @(negedge clk);
                w++;
            end
            chk($sformatf("%s_ready%0d", tag, i), 80'(pix_ready), 80'(1));
            @(negedge clk);
        end
        pix_valid = 1'b0;
        pix_last  = 1'b0;
        wait_not_busy(tag, 2000);
        compare(tag, base, 1'b0);
        chk($sformatf("%s_ready_cycles", tag), 80'(pix_rdy_cycles - rb), 80'(n));
        chk($sformatf("%s_done", tag), 80'(done), 80'(1));
    endtask

    task automatic random_rom(input bit allow_end);
        for (int a = 0; a < 8; a++) begin
            int r;
            r = int'($urandom_range(7, 0));
            if (r <= 2)                   rom[a] = {2'b00, 8'($urandom)};
            else if (r <= 5)              rom[a] = {2'b01, 8'($urandom)};
            else if (r == 6 || !allow_end) rom[a] = {2'b10, 8'($urandom_range(3, 0))};
            else                          rom[a] = {2'b11, 8'($urandom)};
        end
    endtask

    initial begin
        int base, rb, n;
        for (int a = 0; a < 8; a++) rom[a] = 10'h3FF;

        // reset state
        repeat (3) @(negedge clk);
        chk("rst_busy", 80'(busy), 80'(0));
        chk("rst_done", 80'(done), 80'(0));
        chk("rst_error", 80'(error), 80'(0));
        chk("rst_msel", 80'(m_sel), 80'(0));
        chk("rst_mread", 80'(m_read), 80'(0));
        chk("rst_mask", 80'(m_write_mask), 80'(0));
        chk("rst_addr", 80'(m_address), 80'(0));
        chk("rst_wval", 80'(m_write_value), 80'(0));
        chk("rst_rom_addr", 80'(rom_addr), 80'(0));
        chk("rst_pix_ready", 80'(pix_ready), 80'(0));
        reset_n = 1'b1;

        // pixels offered while IDLE are ignored
        base = obs_q.size(); rb = pix_rdy_cycles;
        pix_valid = 1'b1; pix_data = 16'h1234;
        repeat (6) @(negedge clk);
        pix_valid = 1'b0;
        chk("idle_pix_txns", 80'(obs_q.size() - base), 80'(0));
        chk("idle_pix_ready", 80'(pix_rdy_cycles - rb), 80'(0));

        // basic init: cmd 0x01, data 0x11, end; start re-pulsed while busy
        rom[0] = 10'h001; rom[1] = 10'h111; rom[2] = 10'h3A5;
        busy_k = 2; stall_max = 0; stall_rand = 1'b0;
        run_init("init_basic", 1'b1, 1'b0);

        // directed frame, then random frame (RAMWR resent)
        frame_px[0] = 16'hF800; frame_px[1] = 16'h07E0;
        run_frame("frame_dir", 2);
        for (int i = 0; i < 3; i++) frame_px[i] = 16'($urandom);
        busy_k = 1;
        run_frame("frame_rand", 3);

        // start in STREAM_IDLE restarts init; wait states held 4 cycles
        busy_k = 2; stall_max = 3; stall_rand = 1'b0;
        run_init("init_stall", 1'b0, 1'b1);

        // delay entry: 5 * DELAY_UNIT clocks with no bus traffic
        rom[0] = 10'h205; rom[1] = 10'h300; stall_max = 0;
        base = obs_q.size();
        pulse_start();
        n = 0;
        while (!done && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk("delay_done", 80'(done), 80'(1));
        chk("delay_txns", 80'(obs_q.size() - base), 80'(0));
        chk("delay_len_ok", 80'((n >= 50) && (n <= 56)), 80'(1));
        chk("delay_busy", 80'(busy), 80'(0));
        frame_px[0] = 16'($urandom);
        mdl_dc = -1;
        run_frame("frame_after_delay", 1);

        // randomized init ROMs with frames; one ROM has no end marker
        for (int it = 0; it < 4; it++) begin
            random_rom(it != 2);
            busy_k = int'($urandom_range(3, 0));
            stall_max = 2; stall_rand = 1'b1;
            run_init($sformatf("init_rand%0d", it), 1'b0, 1'b0);
            frame_px[0] = 16'($urandom); frame_px[1] = 16'($urandom);
            run_frame($sformatf("frame_rand%0d", it), 2);
        end

        // STATUS stuck busy: POLL_MAX reads then error
        rom[0] = 10'h001; rom[1] = 10'h300;
        busy_k = 1000; stall_max = 0; stall_rand = 1'b0;
        run_init("timeout", 1'b0, 1'b0);
        chk("timeout_busy", 80'(busy), 80'(0));

        // reset while a CTRL write is pending
        busy_k = 1; stall_max = 3;
        pulse_start();
        n = 0;
        while (!(m_sel && m_address == 32'h4) && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("rst_mid_reach_ctrl", 80'(m_sel && m_address == 32'h4), 80'(1));
        #1 reset_n = 1'b0;
        #1;
        chk("rst_mid_msel", 80'(m_sel), 80'(0));
        chk("rst_mid_busy", 80'(busy), 80'(0));
        @(negedge clk);
        reset_n = 1'b1;
        base = obs_q.size();
        repeat (20) @(negedge clk);
        chk("rst_mid_quiet", 80'(obs_q.size() - base), 80'(0));
        chk("rst_mid_busy_after", 80'(busy), 80'(0));
        chk("rst_mid_done_after", 80'(done), 80'(0));

        // protocol invariants across the whole run
        chk("bus_stable", 80'(stab_viol), 80'(0));
        chk("bus_gap", 80'(gap_viol), 80'(0));
        chk("ready_vs_bus", 80'(pr_viol), 80'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
